datapath_sequencer: RTL
=======================

// Module: datapath_sequencer
// PURPOSE
//  Multicycle sequencer for the 12-bit RISC-V subset datapath (lw, sw, beq, R-type add/sub/and/or/srl, andi/ori).
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Owns the PC and instruction register; issues one-cycle stage strobes to the register file, ALU and data memory.
//  Drives req/ack handshakes to instruction and data memory.
// PARAMETERS
//  PC_W         12  PC width; word index, wraps modulo 2**PC_W
//  RESET_PC     0   PC value loaded on reset
//  MEM_WAIT_MAX 15  max cycles waiting for imem_ack/dmem_ack before bus error
//  CNT_W        16  retired-instruction counter width
// PORTS
//  clock          in   1      system clock, rising edge
//  reset          in   1      asynchronous, active-high
//  run            in   1      level; 1 = execute instructions
//  halt_req       in   1      pulse; finish current instruction, then HALT
//  imem_req       out  1      held high in FETCH until ack
//  imem_ack       in   1      instruction valid on imem_rdata
//  imem_rdata     in   32     instruction word
//  pc             out  PC_W   current instruction index
//  ir             out  32     latched instruction
//  branch_taken   in   1      ALU zero && Branch, sampled in EXEC
//  branch_target  in   PC_W   pc + ImmGen from ALU, sampled in EXEC
//  decode_stb     out  1      1-cycle pulse, DECODE
//  exec_stb       out  1      1-cycle pulse, EXEC
//  dmem_req       out  1      held high in MEM until ack
//  dmem_we        out  1      1 = store, valid with dmem_req
//  dmem_ack       in   1      data memory done
//  wb_stb         out  1      1-cycle pulse, WB
//  reg_write_en   out  1      with wb_stb; 0 when ir[11:7]==0
//  busy           out  1      state != IDLE && state != HALT
//  halted         out  1      state == HALT
//  illegal_op     out  1      sticky; unknown opcode/funct
//  bus_err        out  1      sticky; handshake timeout
//  instr_count    out  CNT_W  retired instructions, wraps
// BEHAVIOUR
//  Reset: state IDLE, pc=RESET_PC, ir=0; all strobes, flags, req outputs and instr_count are 0.
//  Reset mid-instruction abandons the instruction; no partial PC update.
//  IDLE: run=1 -> FETCH.
//  FETCH: imem_req=1. Ack in the same cycle: ir<=imem_rdata, go to DECODE next edge.
//    Ack while not in FETCH or MEM is ignored.
//  DECODE: decode_stb=1.
//    Illegal opcode, or R-type funct7/funct3 outside {add,sub,and,or,srl}: illegal_op=1 -> HALT; pc not advanced.
//    Otherwise -> EXEC.
//  EXEC: exec_stb=1.
//    lw/sw -> MEM. R/I -> WB.
//    beq retires here: pc<=branch_taken ? branch_target : pc+1.
//  MEM: dmem_req=1, dmem_we=(sw). On ack: lw -> WB; sw retires.
//  WB: wb_stb=1, reg_write_en=(rd!=0); retires.
//  Retire: pc<=pc+1 (except beq); instr_count++.
//    Next state: halt_req seen since FETCH -> HALT; else run=0 -> IDLE; else FETCH.
//  Latency, acks same-cycle: beq 3, R/I 4, sw 4, lw 5 cycles.
//  Timeout: wait counter clears on state entry. More than MEM_WAIT_MAX cycles without ack in FETCH/MEM:
//    bus_err=1, req dropped -> HALT.
//  HALT: sticky; only reset exits. run and halt_req are ignored.
//  run deasserted mid-instruction: the instruction completes, then IDLE.
//  pc wrap: (2**PC_W-1)+1 -> 0.
// CONFIGURATION
//  SEQ_SINGLE_STEP_EN defined: adds input step (1b pulse). After each retire, go to IDLE;
//    FETCH starts only on step=1 with run=1. halt_req still honoured.
//  Undefined: no step port; runs back-to-back while run=1.
// STRUCTURE
//  seq_pkg: state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT); opcode constants
//    (LOAD 0000011, STORE 0100011, BRANCH 1100011, OP 0110011, OP_IMM 0010011);
//    instr class enum {C_LOAD, C_STORE, C_BRANCH, C_ALU, C_ILLEGAL}.
//  Sub-module seq_opcode_class: combinational ir -> class and legal flag.
// TESTING
//  1. reset, run=1, imem returns add x3,x1,x2 with ack same-cycle -> strobes FETCH,DEC,EXEC,WB;
//     reg_write_en=1; pc 0->1; instr_count=1.
//  2. beq with branch_taken=1, branch_target=0x008 -> no wb_stb, no dmem_req; pc=0x008 after 3 cycles.
//  3. lw with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0; wb_stb 1 cycle after ack; 5+3 cycles total.
//  4. opcode 1111111 -> illegal_op=1, halted=1, pc unchanged; later run/imem_ack ignored until reset.
//  5. dmem_ack withheld -> after MEM_WAIT_MAX+1 cycles: bus_err=1, dmem_req=0, halted=1.
//  6. reset asserted mid-MEM -> same cycle: dmem_req=0, pc=RESET_PC, state IDLE;
//     with SEQ_SINGLE_STEP_EN, each step pulse retires exactly one instruction.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types for the multicycle datapath sequencer: FSM states, RV32 opcodes, instruction classes.
// Latency: n/a (types and a pure function). Backpressure: n/a.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    typedef enum logic [2:0] {
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_ALU,
        C_ILLEGAL
    } instr_class_t;

    // The ALU only implements add, sub, and, or, srl for register-register ops.
    function automatic logic r_type_legal(input logic [6:0] funct7, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        if (funct7 == 7'b0000000) begin
            ok = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                 (funct3 == 3'b110) || (funct3 == 3'b101);
        end else if (funct7 == 7'b0100000) begin
            ok = (funct3 == 3'b000);
        end
        return ok;
    endfunction

endpackage

// File: rtl/seq_opcode_class.sv
// Classifies the latched instruction into load/store/branch/alu/illegal.
// Latency: combinational. Backpressure: none.
module seq_opcode_class
    import seq_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output instr_class_t instr_class,
    output logic         legal
);

    always_comb begin
        instr_class = C_ILLEGAL;
        case (opcode)
            LOAD:    instr_class = C_LOAD;
            STORE:   instr_class = C_STORE;
            BRANCH:  instr_class = C_BRANCH;
            OP:      instr_class = r_type_legal(funct7, funct3) ? C_ALU : C_ILLEGAL;
            OP_IMM:  instr_class = C_ALU;
            default: instr_class = C_ILLEGAL;
        endcase
    end

    assign legal = (instr_class != C_ILLEGAL);

endmodule

// File: rtl/datapath_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer owning pc and ir; SEQ_SINGLE_STEP_EN adds a step input.
// Latency: beq 3, R/I 4, sw 4, lw 5 cycles with same-cycle acks; each ack wait adds a cycle.
// Backpressure: req held until ack; no ack within MEM_WAIT_MAX+1 cycles -> bus_err and HALT.
module datapath_sequencer
    import seq_pkg::*;
#(
    parameter int              PC_W         = 12,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              MEM_WAIT_MAX = 15,
    parameter int              CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             halt_req,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [PC_W-1:0]  pc,
    output logic [31:0]      ir,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    output logic             decode_stb,
    output logic             exec_stb,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             wb_stb,
    output logic             reg_write_en,
    output logic             busy,
    output logic             halted,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              halt_pend;
    instr_class_t      cls;
    logic              legal;
    logic              retire;
    logic              timeout;
    logic              fetch_go;
    logic              retire_idle;

    seq_opcode_class u_class (
        .opcode      (ir[6:0]),
        .funct3      (ir[14:12]),
        .funct7      (ir[31:25]),
        .instr_class (cls),
        .legal       (legal)
    );

`ifdef SEQ_SINGLE_STEP_EN
    assign fetch_go    = run && step;
    assign retire_idle = 1'b1;
`else
    assign fetch_go    = run;
    assign retire_idle = !run;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        imem_req     = 1'b0;
        decode_stb   = 1'b0;
        exec_stb     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        wb_stb       = 1'b0;
        reg_write_en = 1'b0;
        retire       = 1'b0;
        timeout      = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_go) state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nxt = DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = HALT;
                end
            end
            DECODE: begin
                decode_stb = 1'b1;
                state_nxt  = legal ? EXEC : HALT;
            end
            EXEC: begin
                exec_stb = 1'b1;
                case (cls)
                    C_LOAD, C_STORE: state_nxt = MEM;
                    C_BRANCH:        retire    = 1'b1;
                    default:         state_nxt = WB;
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == C_STORE);
                if (dmem_ack) begin
                    if (cls == C_STORE) retire    = 1'b1;
                    else                state_nxt = WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = HALT;
                end
            end
            WB: begin
                wb_stb       = 1'b1;
                reg_write_en = (ir[11:7] != 5'd0);
                retire       = 1'b1;
            end
            default: state_nxt = HALT;
        endcase
        // A halt request arriving in the retire cycle itself still counts.
        if (retire) begin
            if (halt_pend || halt_req) state_nxt = HALT;
            else if (retire_idle)      state_nxt = IDLE;
            else                       state_nxt = FETCH;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            ir          <= '0;
            wait_cnt    <= '0;
            halt_pend   <= 1'b0;
            illegal_op  <= 1'b0;
            bus_err     <= 1'b0;
            instr_count <= '0;
        end else begin
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (state == FETCH || state == MEM)
                wait_cnt <= wait_cnt + 1'b1;

            if (state_nxt == FETCH && state != FETCH)
                halt_pend <= 1'b0;
            else if (busy)
                halt_pend <= halt_pend || halt_req;

            if (state == FETCH && imem_ack)
                ir <= imem_rdata;
            if (state == DECODE && !legal)
                illegal_op <= 1'b1;
            if (timeout)
                bus_err <= 1'b1;

            if (retire) begin
                instr_count <= instr_count + 1'b1;
                pc <= (state == EXEC && branch_taken) ? branch_target : pc + 1'b1;
            end
        end
    end

    assign busy   = (state != IDLE) && (state != HALT);
    assign halted = (state == HALT);

endmodule
